// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and operand/product types for the array multiplier
package mult_pkg;

  localparam int WIDTH  = 8;
  localparam int PWIDTH = 2 * WIDTH;

  typedef logic [WIDTH-1:0]  operand_t;
  typedef logic [PWIDTH-1:0] product_t;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder; tie cin low to use it as a half adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/array_multiplier_8bit.sv
// rtl/array_multiplier_8bit.sv - unsigned AND/full-adder array multiplier with a registered product
module array_multiplier_8bit
  import mult_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  operand_t A,
  input  operand_t B,
  input  logic     in_valid,
  output product_t P,
  output logic     out_valid
);

  operand_t       pp       [WIDTH];
  // row_sum[i] is the running sum after row i, aligned so bit 0 has weight 2^i
  logic [WIDTH:0] row_sum  [WIDTH];
  product_t       product;

  genvar gi, gj;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = A & {WIDTH{B[gi]}};
    end
  endgenerate

  assign row_sum[0] = {1'b0, pp[0]};

  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_row
      logic [WIDTH:0]   carry;
      logic [WIDTH-1:0] sum_bits;

      assign carry[0] = 1'b0;

      for (gj = 0; gj < WIDTH; gj++) begin : g_cell
        full_adder_cell u_fa (
          .a    (pp[gi][gj]),
          .b    (row_sum[gi-1][gj+1]),
          .cin  (carry[gj]),
          .sum  (sum_bits[gj]),
          .cout (carry[gj+1])
        );
      end

      assign row_sum[gi] = {carry[WIDTH], sum_bits};
    end
  endgenerate

  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_low_bits
      assign product[gi] = row_sum[gi][0];
    end
  endgenerate

  // The last row supplies bit WIDTH-1 and every upper bit including the final carry.
  assign product[PWIDTH-1:WIDTH-1] = row_sum[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        P <= product;
      end
    end
  end

endmodule

// File: tb/tb_array_multiplier_8bit.sv
// tb/tb_array_multiplier_8bit.sv - randomized and directed checks of the array multiplier
module tb_array_multiplier_8bit;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        in_valid;
  logic [15:0] P;
  logic        out_valid;

  int n_vec;
  int n_bad;

  int unsigned exp_p;
  bit          exp_v;
  bit          model_ok;

  array_multiplier_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .P         (P),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the registered outputs must hold after each edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_p    = 0;
      exp_v    = 1'b0;
      model_ok = 1'b1;
    end else begin
      exp_v = in_valid;
      if (in_valid) exp_p = int'(A) * int'(B);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      n_vec++;
      if (P !== exp_p[15:0] || out_valid !== exp_v) begin
        n_bad++;
        $display("FAIL model t=%0t P=%0d out_valid=%b expected P=%0d out_valid=%b",
                 $time, P, out_valid, exp_p, exp_v);
      end
    end
  end

  task automatic step(input int a, input int b, input bit v, input bit r);
    A        = a[7:0];
    B        = b[7:0];
    in_valid = v;
    rst      = r;
    @(negedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int want_p, input bit want_v);
    n_vec++;
    if (P !== want_p[15:0] || out_valid !== want_v) begin
      n_bad++;
      $display("FAIL %s P=%0d out_valid=%b expected P=%0d out_valid=%b",
               name, P, out_valid, want_p, want_v);
    end
  endtask

  int dir_a [5] = '{5, 15, 100, 255, 255};
  int dir_b [5] = '{10, 15, 2, 1, 255};
  int dir_p [5] = '{50, 225, 200, 255, 65025};

  int zer_a [4] = '{0, 200, 1, 128};
  int zer_b [4] = '{200, 0, 173, 2};
  int zer_p [4] = '{0, 0, 173, 256};

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    model_ok = 1'b0;
    exp_p    = 0;
    exp_v    = 1'b0;
    A        = 8'd0;
    B        = 8'd0;
    in_valid = 1'b0;
    rst      = 1'b1;

    step(255, 255, 1, 1);
    step(255, 255, 1, 1);
    check_lit("reset_hold", 0, 1'b0);
    step(255, 255, 1, 0);
    check_lit("reset_release", 65025, 1'b1);

    for (int i = 0; i < 5; i++) begin
      step(dir_a[i], dir_b[i], 1, 0);
      check_lit($sformatf("directed_%0dx%0d", dir_a[i], dir_b[i]), dir_p[i], 1'b1);
    end

    step(15, 15, 1, 0);
    check_lit("hold_setup", 225, 1'b1);
    step(7, 9, 0, 0);
    check_lit("hold_idle", 225, 1'b0);
    step(7, 9, 1, 0);
    check_lit("hold_resume", 63, 1'b1);

    for (int i = 0; i < 4; i++) begin
      step(zer_a[i], zer_b[i], 1, 0);
      check_lit($sformatf("edge_%0dx%0d", zer_a[i], zer_b[i]), zer_p[i], 1'b1);
    end

    step(255, 255, 1, 1);
    check_lit("reset_midstream", 0, 1'b0);
    step(3, 4, 1, 0);
    check_lit("after_reset", 12, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      step(int'($urandom_range(255)), int'($urandom_range(255)),
           ($urandom_range(7) != 0), ($urandom_range(49) == 0));
    end

    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
